// File: rtl/chess_timer_pkg.sv
// Shared definitions for the chess game timer: FSM states and player encoding.
package chess_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN_WHITE,
        RUN_BLACK,
        TIMEOUT
    } timerState_t;

    localparam logic WHITE_PLAYER = 1'b1;
    localparam logic BLACK_PLAYER = 1'b0;

endpackage

// File: rtl/second_tick_generator.sv
// Prescaler producing a one-cycle tick every CLOCK_FREQUENCY cycles while enabled.
module second_tick_generator #(
    parameter int CLOCK_FREQUENCY = 50000000
) (
    input  logic clock,
    input  logic resetApp,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int COUNT_WIDTH = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CLOCK_FREQUENCY - 1);

    logic [COUNT_WIDTH-1:0] count;

    // A disabled prescaler sits at zero so every turn starts with a full second.
    always_ff @(posedge clock) begin
        if (resetApp || clear || !enable) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST_COUNT);

endmodule

// File: rtl/chess_game_timer.sv
// Two-player chess clock with per-side second counters and timeout detection.
// Optional per-move increment is enabled by defining CHESS_INCREMENT_EN.
module chess_game_timer
    import chess_timer_pkg::*;
#(
    parameter int CLOCK_FREQUENCY   = 50000000,
    parameter int GAME_SECONDS      = 600,
    parameter int TIME_WIDTH        = 10,
    parameter int INCREMENT_SECONDS = 5
) (
    input  logic                  clock,
    input  logic                  resetApp,
    input  logic                  Start,
    input  logic                  Player,
    output logic [TIME_WIDTH-1:0] WhiteTime,
    output logic [TIME_WIDTH-1:0] BlackTime,
    output logic                  Running,
    output logic                  Timeout,
    output logic                  Winner
);

    localparam logic [TIME_WIDTH-1:0] START_TIME = TIME_WIDTH'(GAME_SECONDS);

    timerState_t           state, nextState;
    logic [TIME_WIDTH-1:0] nextWhite, nextBlack;
    logic                  nextWinner;
    logic                  playerReg;
    logic                  running;
    logic                  move;
    logic                  tick;
    logic                  prescalerClear;

`ifdef CHESS_INCREMENT_EN
    function automatic logic [TIME_WIDTH-1:0] addIncrement(input logic [TIME_WIDTH-1:0] t);
        logic [TIME_WIDTH:0] sum;
        sum = {1'b0, t} + (TIME_WIDTH + 1)'(INCREMENT_SECONDS);
        return sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
    endfunction
`endif

    assign running        = (state == RUN_WHITE) || (state == RUN_BLACK);
    assign move           = running && (Player != playerReg);
    assign prescalerClear = ((state == IDLE) && Start) || move;

    second_tick_generator #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
    ) tickGen (
        .clock   (clock),
        .resetApp(resetApp),
        .clear   (prescalerClear),
        .enable  (running),
        .tick    (tick)
    );

    always_ff @(posedge clock) begin
        if (resetApp) begin
            state     <= IDLE;
            WhiteTime <= START_TIME;
            BlackTime <= START_TIME;
            Winner    <= 1'b0;
            playerReg <= Player;
        end else begin
            state     <= nextState;
            WhiteTime <= nextWhite;
            BlackTime <= nextBlack;
            Winner    <= nextWinner;
            playerReg <= Player;
        end
    end

    // A move outranks a coincident tick; the clock that hits zero loses.
    always_comb begin
        nextState  = state;
        nextWhite  = WhiteTime;
        nextBlack  = BlackTime;
        nextWinner = Winner;
        case (state)
            IDLE: begin
                if (Start) begin
                    nextState = (Player == WHITE_PLAYER) ? RUN_WHITE : RUN_BLACK;
                end
            end
            RUN_WHITE: begin
                if (move) begin
                    nextState = (Player == WHITE_PLAYER) ? RUN_WHITE : RUN_BLACK;
`ifdef CHESS_INCREMENT_EN
                    nextWhite = addIncrement(WhiteTime);
`endif
                end else if (tick) begin
                    if (WhiteTime <= 1) begin
                        nextWhite  = '0;
                        nextState  = TIMEOUT;
                        nextWinner = BLACK_PLAYER;
                    end else begin
                        nextWhite = WhiteTime - 1'b1;
                    end
                end
            end
            RUN_BLACK: begin
                if (move) begin
                    nextState = (Player == WHITE_PLAYER) ? RUN_WHITE : RUN_BLACK;
`ifdef CHESS_INCREMENT_EN
                    nextBlack = addIncrement(BlackTime);
`endif
                end else if (tick) begin
                    if (BlackTime <= 1) begin
                        nextBlack  = '0;
                        nextState  = TIMEOUT;
                        nextWinner = WHITE_PLAYER;
                    end else begin
                        nextBlack = BlackTime - 1'b1;
                    end
                end
            end
            TIMEOUT: begin
                nextState = TIMEOUT;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign Running = running;
    assign Timeout = (state == TIMEOUT);

endmodule

// File: tb/tb_chess_game_timer.sv
// Self-checking bench for chess_game_timer with a small seconds-and-turns reference model.
module tb_chess_game_timer;

    localparam int CF  = 4;
    localparam int GS  = 3;
    localparam int TW  = 10;
    localparam int INC = 2;

    logic          clock = 1'b0;
    logic          resetApp = 1'b1;
    logic          Start = 1'b0;
    logic          Player = 1'b1;
    logic [TW-1:0] WhiteTime, BlackTime;
    logic          Running, Timeout, Winner;

    int checks = 0;
    int errors = 0;

    // Reference model: whose turn it is, cycles elapsed in the current second, seconds left.
    bit mRunning, mSide, mTimeout, mWinner, mPrev;
    int mWhite, mBlack, mElapsed;

    chess_game_timer #(
        .CLOCK_FREQUENCY  (CF),
        .GAME_SECONDS     (GS),
        .TIME_WIDTH       (TW),
        .INCREMENT_SECONDS(INC)
    ) dut (
        .clock    (clock),
        .resetApp (resetApp),
        .Start    (Start),
        .Player   (Player),
        .WhiteTime(WhiteTime),
        .BlackTime(BlackTime),
        .Running  (Running),
        .Timeout  (Timeout),
        .Winner   (Winner)
    );

    always #5 clock = ~clock;

    function automatic int bump(input int t);
        int maxVal = (1 << TW) - 1;
        return (t + INC > maxVal) ? maxVal : t + INC;
    endfunction

    task automatic modelStep(input bit rst, input bit st, input bit pl);
        if (rst) begin
            mRunning = 0; mTimeout = 0; mWinner = 0;
            mWhite = GS; mBlack = GS; mElapsed = 0; mPrev = pl;
            return;
        end
        if (!mRunning && !mTimeout) begin
            if (st) begin
                mRunning = 1; mSide = pl; mElapsed = 0;
            end
        end else if (mRunning) begin
            if (pl != mPrev) begin
`ifdef CHESS_INCREMENT_EN
                if (mSide) mWhite = bump(mWhite); else mBlack = bump(mBlack);
`endif
                mSide = pl; mElapsed = 0;
            end else if (mElapsed == CF - 1) begin
                int left;
                mElapsed = 0;
                left = mSide ? mWhite : mBlack;
                left = (left > 0) ? left - 1 : 0;
                if (mSide) mWhite = left; else mBlack = left;
                if (left == 0) begin
                    mRunning = 0; mTimeout = 1; mWinner = !mSide;
                end
            end else begin
                mElapsed++;
            end
        end
        mPrev = pl;
    endtask

    task automatic step(input bit rst, input bit st, input bit pl);
        resetApp = rst; Start = st; Player = pl;
        modelStep(rst, st, pl);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 1);
        step(1, 1, 1);
        checks++;
        if ({Running, Timeout, Winner, WhiteTime, BlackTime} !== {3'b000, TW'(GS), TW'(GS)}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h",
                     {Running, Timeout, Winner, WhiteTime, BlackTime}, {3'b000, TW'(GS), TW'(GS)});
        end
        step(0, 0, 0);
        checks++;
        if (Running !== 1'b0) begin
            errors++;
            $display("FAIL start_during_reset: Running=%b expected 0", Running);
        end
    endtask

    task automatic test_countdown_and_timeout();
        step(1, 0, 1);
        step(0, 1, 1);
        checks++;
        if ({Running, WhiteTime} !== {1'b1, TW'(3)}) begin
            errors++;
            $display("FAIL start_white: Running=%b WhiteTime=%0d expected 1/3", Running, WhiteTime);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        checks++;
        if (WhiteTime !== TW'(3)) begin
            errors++;
            $display("FAIL before_first_tick: WhiteTime=%0d expected 3", WhiteTime);
        end
        step(0, 1, 1);
        checks++;
        if ({WhiteTime, BlackTime} !== {TW'(2), TW'(3)}) begin
            errors++;
            $display("FAIL first_tick: White=%0d Black=%0d expected 2/3", WhiteTime, BlackTime);
        end
        for (int i = 0; i < 4; i++) step(0, (i == 1), 1);
        checks++;
        if ({Running, WhiteTime, BlackTime} !== {1'b1, TW'(1), TW'(3)}) begin
            errors++;
            $display("FAIL second_tick: Running=%b White=%0d Black=%0d expected 1/1/3",
                     Running, WhiteTime, BlackTime);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        checks++;
        if ({Running, Timeout, Winner, WhiteTime, BlackTime} !== {3'b010, TW'(0), TW'(3)}) begin
            errors++;
            $display("FAIL white_timeout: got %h expected %h",
                     {Running, Timeout, Winner, WhiteTime, BlackTime}, {3'b010, TW'(0), TW'(3)});
        end
        for (int i = 0; i < 10; i++) step(0, 0, i[0]);
        checks++;
        if ({Running, Timeout, Winner, WhiteTime, BlackTime} !== {3'b010, TW'(0), TW'(3)}) begin
            errors++;
            $display("FAIL timeout_hold: got %h expected %h",
                     {Running, Timeout, Winner, WhiteTime, BlackTime}, {3'b010, TW'(0), TW'(3)});
        end
        step(1, 0, 1);
        checks++;
        if ({Running, Timeout, WhiteTime, BlackTime} !== {2'b00, TW'(3), TW'(3)}) begin
            errors++;
            $display("FAIL reset_in_timeout: got %h expected %h",
                     {Running, Timeout, WhiteTime, BlackTime}, {2'b00, TW'(3), TW'(3)});
        end
    endtask

    task automatic test_move();
        step(1, 0, 1);
        step(0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        step(0, 0, 0);
        checks++;
        if ({Running, WhiteTime, BlackTime} !== {1'b1, TW'(2), TW'(3)}) begin
            errors++;
            $display("FAIL move_to_black: Running=%b White=%0d Black=%0d expected 1/2/3",
                     Running, WhiteTime, BlackTime);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        checks++;
        if (BlackTime !== TW'(3)) begin
            errors++;
            $display("FAIL black_before_tick: BlackTime=%0d expected 3", BlackTime);
        end
        step(0, 0, 0);
        checks++;
        if ({WhiteTime, BlackTime} !== {TW'(2), TW'(2)}) begin
            errors++;
            $display("FAIL black_tick: White=%0d Black=%0d expected 2/2", WhiteTime, BlackTime);
        end
    endtask

    task automatic test_move_on_tick();
        step(1, 0, 1);
        step(0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 0, 0);
        checks++;
        if ({WhiteTime, BlackTime} !== {TW'(3), TW'(3)}) begin
            errors++;
            $display("FAIL move_beats_tick: White=%0d Black=%0d expected 3/3", WhiteTime, BlackTime);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        checks++;
        if (BlackTime !== TW'(3)) begin
            errors++;
            $display("FAIL prescaler_restart: BlackTime=%0d expected 3", BlackTime);
        end
        step(0, 0, 0);
        checks++;
        if (BlackTime !== TW'(2)) begin
            errors++;
            $display("FAIL prescaler_full_second: BlackTime=%0d expected 2", BlackTime);
        end
    endtask

    task automatic test_increment();
        int expWhite;
`ifdef CHESS_INCREMENT_EN
        expWhite = 4;
`else
        expWhite = 2;
`endif
        step(1, 0, 1);
        step(0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        step(0, 0, 0);
        checks++;
        if (WhiteTime !== TW'(expWhite)) begin
            errors++;
            $display("FAIL increment: WhiteTime=%0d expected %0d", WhiteTime, expWhite);
        end
    endtask

    task automatic test_random();
        bit rst, st, pl;
        logic [2*TW+2:0] expected;
        step(1, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            st  = ($urandom_range(0, 5) == 0);
            pl  = ($urandom_range(0, 4) == 0) ? ~Player : Player;
            step(rst, st, pl);
            expected = {mRunning, mTimeout, mWinner, TW'(mWhite), TW'(mBlack)};
            checks++;
            if ({Running, Timeout, Winner, WhiteTime, BlackTime} !== expected) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i,
                         {Running, Timeout, Winner, WhiteTime, BlackTime}, expected);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown_and_timeout();
        test_move();
        test_move_on_tick();
        test_increment();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chess_game_timer.md
CHESS_GAME_TIMER -- requirements
Module: chess_game_timer

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, input clock cycles per second.
REQ-002 SHALL have parameter GAME_SECONDS, default 600, initial time per player in seconds.
REQ-003 SHALL have parameter TIME_WIDTH, default 10, width of each time counter; GAME_SECONDS < 2**TIME_WIDTH.
REQ-004 SHALL have parameter INCREMENT_SECONDS, default 5, per-move bonus, used only under CHESS_INCREMENT_EN.
REQ-005 SHALL have port clock  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port resetApp  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port Start  input  1  single-cycle pulse that starts the game.
REQ-008 SHALL have port Player  input  1  side to move from the move-validation stage, 1 = white, 0 = black.
REQ-009 SHALL have port WhiteTime  output  TIME_WIDTH  white's remaining seconds.
REQ-010 SHALL have port BlackTime  output  TIME_WIDTH  black's remaining seconds.
REQ-011 SHALL have port Running  output  1  high in RUN_WHITE or RUN_BLACK.
REQ-012 SHALL have port Timeout  output  1  high once either clock reaches zero.
REQ-013 SHALL have port Winner  output  1  valid when Timeout is high; 1 = white won, 0 = black won.

Function
REQ-014 SHALL implement states IDLE, RUN_WHITE, RUN_BLACK, TIMEOUT.
REQ-015 SHALL leave IDLE on Start: to RUN_WHITE if Player=1, else RUN_BLACK, on the next edge.
REQ-016 SHALL ignore Start in any state other than IDLE.
REQ-017 SHALL register Player each cycle and detect a change (Player != registered copy) as a move.
REQ-018 SHALL switch RUN_WHITE <-> RUN_BLACK on the edge after a detected move, following the new Player value.
REQ-019 SHALL generate a 1-second tick from a prescaler counting 0..CLOCK_FREQUENCY-1, tick asserted on the cycle the count equals CLOCK_FREQUENCY-1.
REQ-020 SHALL clear the prescaler on Start and on every detected move, so each turn begins with a full second.
REQ-021 SHALL hold the prescaler at 0 in IDLE and TIMEOUT.
REQ-022 SHALL decrement only the running side's counter by 1 on each tick.
REQ-023 SHALL, on a tick while the running counter equals 1, set it to 0 and enter TIMEOUT on the same edge.
REQ-024 SHALL set Winner to the opposite side of the player that timed out.
REQ-025 SHALL give a move priority over a coincident tick: no decrement that cycle.
REQ-026 SHALL ignore Player changes in IDLE and TIMEOUT; TIMEOUT exits only by reset.
REQ-027 SHALL never wrap a counter below 0.

Reset
REQ-028 SHALL on resetApp: state IDLE, WhiteTime=BlackTime=GAME_SECONDS, Running=0, Timeout=0, Winner=0, prescaler=0, registered Player = current Player.
REQ-029 SHALL give reset priority over all inputs, including mid-turn and in TIMEOUT.

Configuration
REQ-030 SHALL, with CHESS_INCREMENT_EN defined, add INCREMENT_SECONDS to the side that just moved on each detected move in a RUN state, saturating at 2**TIME_WIDTH-1.
REQ-031 SHALL, without CHESS_INCREMENT_EN, leave counters unchanged on a move and omit the adder.

Structure
REQ-032 SHALL place the state enum and WHITE_PLAYER=1 / BLACK_PLAYER=0 constants in shared package chess_timer_pkg.
REQ-033 SHALL implement the prescaler as sub-module second_tick_generator (inputs clock, resetApp, clear, enable; output tick).

Verification (CLOCK_FREQUENCY=4, GAME_SECONDS=3, INCREMENT_SECONDS=2)
REQ-034 SHALL cover: reset, Player=1, Start -> RUN_WHITE; WhiteTime 3->2->1 at 4-cycle intervals, BlackTime stays 3.
REQ-035 SHALL cover: no moves after Start -> 12 cycles later WhiteTime=0, Timeout=1, Winner=0, Running=0; later Player toggles ignored.
REQ-036 SHALL cover: Player 1->0 after 6 cycles -> WhiteTime=2, BlackTime decrements 4 cycles after the move.
REQ-037 SHALL cover: Player toggled on the exact tick cycle -> no decrement that cycle, prescaler restarts.
REQ-038 SHALL cover: CHESS_INCREMENT_EN defined, white moves at WhiteTime=2 -> WhiteTime=4; undefined -> stays 2.
REQ-039 SHALL cover: resetApp asserted in TIMEOUT -> IDLE, both counters 3, Timeout=0; Start before reset ignored while running.
